// File: rtl/kpd_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM states, idle patterns
// and one-hot-low helpers used for both row and column lines.
package kpd_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS,
        ST_HOLD,
        ST_RELEASE
    } kpd_state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam logic [3:0] COL_NONE = 4'b1111;

    // True when exactly one line is pulled low; ghosting patterns read as no key.
    function automatic logic is_single_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/kpd_tick_gen.sv
// Free-running divider producing a one-clock scan tick at CLK_HZ/SCAN_HZ.
module kpd_tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == TC) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == TC);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low row drive, debounces press and
// release of a single key, and emits one code/valid event per key stroke.
module keypad_scanner
    import kpd_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic             w_tick;
    logic [3:0]       r_col_m;
    logic [3:0]       r_col_s;
    logic [3:0]       r_row;
    logic [3:0]       r_pat;
    logic [3:0]       r_code_pend;
    logic [DW-1:0]    r_deb;
    logic [DW-1:0]    w_deb_inc;
    logic             w_deb_done;
    kpd_state_t       r_state;

    kpd_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .SCAN_HZ(SCAN_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    // Saturating count; the debounce completes on the tick that reaches the last value.
    assign w_deb_inc  = (r_deb == DEB_LAST) ? r_deb : r_deb + 1'b1;
    assign w_deb_done = (w_deb_inc == DEB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_m     <= COL_NONE;
            r_col_s     <= COL_NONE;
            r_row       <= ROW_IDLE;
            r_pat       <= COL_NONE;
            r_code_pend <= '0;
            r_deb       <= '0;
            r_state     <= ST_SCAN;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
        end else begin
            r_col_m   <= col;
            r_col_s   <= r_col_m;
            key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (is_single_low(r_col_s)) begin
                            r_pat       <= r_col_s;
                            r_code_pend <= {low_idx(r_row), low_idx(r_col_s)};
                            r_deb       <= '0;
                            r_state     <= ST_PRESS;
                        end else begin
                            r_row <= {r_row[2:0], r_row[3]};
                        end
                    end
                    ST_PRESS: begin
                        if (r_col_s == r_pat) begin
                            r_deb <= w_deb_inc;
                            if (w_deb_done) begin
                                key_code  <= r_code_pend;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                r_state   <= ST_HOLD;
                            end
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                    ST_HOLD: begin
                        if (r_col_s == COL_NONE) begin
                            r_deb   <= '0;
                            r_state <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (r_col_s == COL_NONE) begin
                            r_deb <= w_deb_inc;
                            if (w_deb_done) begin
                                key_down <= 1'b0;
                                r_row    <= ROW_IDLE;
                                r_state  <= ST_SCAN;
                            end
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    assign row = r_row;

endmodule
